wave_gen: RTL and testbench
===========================

Name: wave_gen

Overview:
Parametrised multi-mode DAC waveform generator. It is the successor to the fixed 4-bit free-running sawtooth generator that drives a resistor-ladder DAC on the VGA colour pins. It adds runtime-programmable step rate, four waveform modes, enable/freeze, synchronous restart and a period-start strobe. Mode and rate changes are glitch-free and take effect only at period boundaries.

Parameters:
DAC_W, 4, DAC code width in bits; must be >= 2; MAX = 2^DAC_W-1
DIV_W, 10, step-divider width in bits; must be >= 1

Ports:
sys_clk  in  1  system clock (50 MHz board clock)
sys_rst_n  in  1  reset, asynchronous assert, active-low
en  in  1  1 = run; 0 = freeze all state
restart  in  1  synchronous one-cycle request: restart period, load new settings
mode  in  2  0 saw up, 1 saw down, 2 triangle, 3 square
div_val  in  DIV_W  step period = div_val+1 clocks
dac_out  out  DAC_W  DAC code
period_start  out  1  one-cycle strobe on first cycle of each new period

Behaviour:
- Reset: sys_rst_n is asynchronous and active-low; all state is registered on sys_clk.
- State registers:
  - div_cnt (DIV_W bits)
  - phase p (DAC_W bits)
  - dir (up/down)
  - mode_q (2 bits)
  - div_q (DIV_W bits)
  - period_start (registered)
- Reset values: div_cnt=0, p=0, dir=up, mode_q=0, div_q=all ones, period_start=0.
  - Therefore dac_out=0 after reset.
  - Reset defaults reproduce the legacy behaviour: saw up, one step per 2^DIV_W clocks.
- dac_out is a pure function of registered p and mode_q. There is no combinational path from any input.
  - mode 0: p
  - mode 1: MAX-p
  - mode 2: p
  - mode 3: MAX if p[DAC_W-1]=0, else 0
- Divider, when en=1:
  - If div_cnt==div_q: step tick, div_cnt<=0.
  - Else: div_cnt<=div_cnt+1.
  - div_q=0 gives a step every clock.
- Step, modes 0/1/3: p<=p+1, wrapping MAX->0. The wrap completes the period.
- Step, mode 2:
  - dir up, p<MAX: p+1.
  - dir up, p==MAX: p<=MAX-1, dir<=down.
  - dir down, p>1: p-1.
  - dir down, p==1: p<=0, dir<=up. This completes the period.
  - Sequence: 0,1..MAX,MAX-1..1,0; no endpoint repeated.
- Period length:
  - modes 0/1/3: 2^DAC_W steps.
  - mode 2: 2*MAX steps.
  - Each step lasts div_q+1 clocks.
- Period completion, same edge as the step:
  - mode_q<=mode, div_q<=div_val.
  - period_start<=1 for exactly one cycle. It is high in the first cycle that p=0 of the new period.
  - Mode/rate changes made mid-period are ignored until the next completion.
- restart=1 (priority over en and over any step tick on the same edge):
  - div_cnt<=0, p<=0, dir<=up.
  - mode_q<=mode, div_q<=div_val.
  - period_start<=1 next cycle.
- en=0 and no restart:
  - div_cnt, p, dir, mode_q, div_q all hold.
  - period_start<=0.
  - dac_out holds its last value.
  - Resuming continues mid-step from the held div_cnt.
- No period_start after reset release until the first completion or restart.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clock.

Test Plan:
- Reset then en=1, mode=0, div_val=3 (ignored until boundary), DAC_W=4, DIV_W=10 -> dac_out steps 0..15 every 1024 clocks. At the 15->0 wrap, period_start pulses one cycle and div_q becomes 3; steps then occur every 4 clocks.
- restart with mode=2, div_val=0 -> dac_out sequence 0,1..15,14..1,0, one step per clock, period 30 clocks. period_start high on cycles 1, 31, 61 after restart.
- Running mode 0, div 1; change mode to 1 at p=5 -> output stays saw up until wrap. First cycle of the next period shows dac_out=15 with period_start=1, then 14, 13, ...
- mode=3, div_val=0 restart -> dac_out=15 for 8 clocks, 0 for 8 clocks, repeating; period_start every 16 clocks.
- Mid-period en=0 for 50 clocks, div_val=2, at p=9, div_cnt=1 -> dac_out frozen at 9 with no strobe. On en=1 the next step occurs after 2 clocks; the rest of the period is unchanged.
- restart and step tick (wrap) on the same edge -> single period_start, p=0, div_cnt=0. Separately, assert sys_rst_n low asynchronously mid-triangle -> dac_out=0 immediately and mode_q=0.

Source files
------------

// File: rtl/wave_gen.sv
// Multi-mode DAC waveform generator: saw up/down, triangle and square with a
// programmable step divider; mode/rate are reloaded only at period boundaries.
module wave_gen #(
  parameter int DAC_W = 4,
  parameter int DIV_W = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  output logic [DAC_W-1:0] dac_out,
  output logic             period_start
);

  localparam logic [DAC_W-1:0] MAX   = '1;
  localparam logic [DAC_W-1:0] P_ONE = DAC_W'(1);
  localparam logic [DIV_W-1:0] D_ONE = DIV_W'(1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DAC_W-1:0] p_q, p_d;
  dir_e             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ps_q, ps_d;
  logic             tick;
  logic             wrap;

  assign tick = (div_cnt_q == div_q);

  always_comb begin
    div_cnt_d = div_cnt_q;
    p_d       = p_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    div_d     = div_q;
    ps_d      = 1'b0;
    wrap      = 1'b0;

    if (restart) begin
      div_cnt_d = '0;
      p_d       = '0;
      dir_d     = DIR_UP;
      mode_d    = mode;
      div_d     = div_val;
      ps_d      = 1'b1;
    end else if (en) begin
      if (tick) begin
        div_cnt_d = '0;
        if (mode_q == 2'd2) begin
          // Triangle turns around without repeating either endpoint.
          if (dir_q == DIR_UP) begin
            if (p_q == MAX) begin
              p_d   = MAX - P_ONE;
              dir_d = DIR_DOWN;
            end else begin
              p_d = p_q + P_ONE;
            end
          end else if (p_q == P_ONE) begin
            p_d   = '0;
            dir_d = DIR_UP;
            wrap  = 1'b1;
          end else begin
            p_d = p_q - P_ONE;
          end
        end else begin
          p_d  = p_q + P_ONE;
          wrap = (p_q == MAX);
        end

        if (wrap) begin
          mode_d = mode;
          div_d  = div_val;
          ps_d   = 1'b1;
        end
      end else begin
        div_cnt_d = div_cnt_q + D_ONE;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_q <= '0;
      p_q       <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= 2'd0;
      div_q     <= '1;
      ps_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      p_q       <= p_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      ps_q      <= ps_d;
    end
  end

  always_comb begin
    dac_out = p_q;
    case (mode_q)
      2'd1:    dac_out = MAX - p_q;
      2'd3:    dac_out = p_q[DAC_W-1] ? '0 : MAX;
      default: dac_out = p_q;
    endcase
  end

  assign period_start = ps_q;

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: a period/step-index reference model is
// compared against dac_out and period_start on every falling clock edge.
module tb_wave_gen;

  localparam int DAC_W = 4;
  localparam int DIV_W = 10;
  localparam int MAXV  = (1 << DAC_W) - 1;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             en;
  logic             restart;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div_val;
  logic [DAC_W-1:0] dac_out;
  logic             period_start;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: step index within the period and clock within the step.
  int m_mode, m_div, m_k, m_c, m_ps;

  wave_gen #(.DAC_W(DAC_W), .DIV_W(DIV_W)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .en           (en),
    .restart      (restart),
    .mode         (mode),
    .div_val      (div_val),
    .dac_out      (dac_out),
    .period_start (period_start)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int period_len(input int md);
    return (md == 2) ? 2 * MAXV : MAXV + 1;
  endfunction

  function automatic int exp_dac(input int md, input int k);
    case (md)
      0:       return k;
      1:       return MAXV - k;
      2:       return (k <= MAXV) ? k : 2 * MAXV - k;
      default: return (k < (MAXV + 1) / 2) ? MAXV : 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_div  = (1 << DIV_W) - 1;
    m_k    = 0;
    m_c    = 0;
    m_ps   = 0;
  endtask

  task automatic model_clock();
    m_ps = 0;
    if (restart) begin
      m_k = 0; m_c = 0; m_mode = mode; m_div = div_val; m_ps = 1;
    end else if (en) begin
      if (m_c == m_div) begin
        m_c = 0;
        m_k++;
        if (m_k == period_len(m_mode)) begin
          m_k = 0; m_mode = mode; m_div = div_val; m_ps = 1;
        end
      end else begin
        m_c++;
      end
    end
  endtask

  // Inputs are driven at the falling edge; one call = one rising edge + check.
  task automatic cycle(input string tag);
    @(posedge sys_clk);
    model_clock();
    @(negedge sys_clk);
    chk({tag, "_dac"}, int'(dac_out), exp_dac(m_mode, m_k));
    chk({tag, "_ps"}, int'(period_start), m_ps);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    en        = 1'b0;
    restart   = 1'b0;
    mode      = 2'd0;
    div_val   = '0;
    model_reset();
    #23;
    chk("rst_dac", int'(dac_out), 0);
    chk("rst_ps", int'(period_start), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Legacy default: saw up at 1024 clocks/step, new divider applied at the wrap.
    en = 1'b1; mode = 2'd0; div_val = 10'd3;
    run("legacy", 16 * 1024 + 40);

    // Triangle, one step per clock.
    restart = 1'b1; mode = 2'd2; div_val = '0;
    cycle("tri_rs");
    restart = 1'b0;
    run("tri", 70);

    // Saw up div 1, mode change mid-period only takes effect at the wrap.
    restart = 1'b1; mode = 2'd0; div_val = 10'd1;
    cycle("mchg_rs");
    restart = 1'b0;
    while (m_k != 5) cycle("mchg_a");
    mode = 2'd1;
    run("mchg_b", 60);

    // Square.
    restart = 1'b1; mode = 2'd3; div_val = '0;
    cycle("sq_rs");
    restart = 1'b0;
    run("sq", 40);

    // Freeze mid-step at p=9, div 2.
    restart = 1'b1; mode = 2'd0; div_val = 10'd2;
    cycle("frz_rs");
    restart = 1'b0;
    while (!(m_k == 9 && m_c == 1)) cycle("frz_a");
    en = 1'b0; mode = 2'd2;
    run("frz_hold", 50);
    en = 1'b1;
    run("frz_run", 40);

    // Restart on the same edge as a wrap tick.
    restart = 1'b1; mode = 2'd0; div_val = '0;
    cycle("rw_rs");
    restart = 1'b0;
    while (m_k != MAXV) cycle("rw_a");
    restart = 1'b1; mode = 2'd0;
    cycle("rw_hit");
    restart = 1'b0;
    run("rw_after", 5);

    // Randomised stretch.
    for (int i = 0; i < 3000; i++) begin
      restart = ($urandom_range(0, 99) < 2);
      en      = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) div_val = DIV_W'($urandom_range(0, 3));
      cycle("rand");
    end

    // Asynchronous reset in the middle of a triangle.
    restart = 1'b1; en = 1'b1; mode = 2'd2; div_val = '0;
    cycle("ar_rs");
    restart = 1'b0;
    run("ar_a", 7);
    #3;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_dac", int'(dac_out), 0);
    chk("arst_ps", int'(period_start), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mode = 2'd2;
    run("ar_post", 1030);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
